// File: rtl/uart_tx_stream_if.sv
// FIFO-to-transmitter byte handshake: valid/data from the FIFO, yumi pop strobe back.
// Member names match the FIFO-side port names so both ends read the same.
interface uart_tx_stream_if #(
    parameter int data_bits_p = 8
) ();
    logic                   valid_i;
    logic [data_bits_p-1:0] data_i;
    logic                   yumi_o;

    modport master (output valid_i, output data_i, input yumi_o);
    modport slave  (input valid_i, input data_i, output yumi_o);
endinterface

// File: rtl/uart_tx_stream.sv
// UART frame transmitter fed from the board-side byte FIFO.
// Frames are start, data LSB-first, optional parity, then stop bits; back-to-back when the FIFO stays full.
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when parity_p != 0)
// STOP   | stop bit(s), line high
module uart_tx_stream #(
    parameter int clks_per_bit_p = 104,
    parameter int data_bits_p    = 8,
    parameter int parity_p       = 0,
    parameter int stop_bits_p    = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    uart_tx_stream_if.slave        fifo_if,
    output logic                   tx_o,
    output logic                   busy_o
);
    localparam int baud_w = $clog2(clks_per_bit_p);
    localparam int bit_w  = $clog2(data_bits_p);

    localparam logic [baud_w-1:0] baud_last = baud_w'(clks_per_bit_p - 1);
    localparam logic [bit_w-1:0]  data_last = bit_w'(data_bits_p - 1);
    localparam logic [bit_w-1:0]  stop_last = bit_w'(stop_bits_p - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [baud_w-1:0]      baud_q, baud_d;
    logic [bit_w-1:0]       bit_q, bit_d;
    logic [data_bits_p-1:0] shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;

    logic baud_end;
    logic last_stop;
    logic yumi;
    logic par_calc;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = '0;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_d     = tx_q;

        baud_end  = (baud_q == baud_last);
        last_stop = (state_q == STOP) && (bit_q == stop_last) && baud_end;
        yumi      = fifo_if.valid_i && !reset_i && ((state_q == IDLE) || last_stop);
        par_calc  = (parity_p == 1) ? ~^fifo_if.data_i : ^fifo_if.data_i;

        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                bit_d = '0;
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == data_last) begin
                        state_d = (parity_p != 0) ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (bit_q == stop_last) begin
                        state_d = IDLE;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bit_d   = '0;
            end
        endcase

        // A pop overrides whatever the frame logic chose: the new byte starts next cycle.
        if (yumi) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = fifo_if.data_i;
            par_d   = (parity_p != 0) ? par_calc : 1'b0;
        end

        // tx is registered from the next state so the line never sees a combinational input path.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign fifo_if.yumi_o = yumi;
    assign tx_o           = tx_q;
    assign busy_o         = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        assert (clks_per_bit_p >= 2 && data_bits_p >= 5 && data_bits_p <= 8 &&
                parity_p >= 0 && parity_p <= 2 && stop_bits_p >= 1 && stop_bits_p <= 2)
        else $error("uart_tx_stream: illegal parameter combination");
    end
endmodule

// File: tb/tb_uart_tx_stream.sv
// Lockstep check of three transmitter configurations against a frame-level reference model.
// Each configuration has its own byte FIFO image; every cycle tx_o, busy_o and yumi_o are compared.
module tb_uart_tx_stream;
    localparam int CPB  [3] = '{4, 4, 2};
    localparam int DB   [3] = '{8, 8, 7};
    localparam int PAR  [3] = '{0, 2, 1};
    localparam int SB   [3] = '{1, 2, 1};

    logic       clk;
    logic       reset;
    logic [2:0] valid_v;
    logic [7:0] data_v [3];
    logic [2:0] yumi_w, tx_w, busy_w;

    uart_tx_stream_if #(.data_bits_p(8)) if0 ();
    uart_tx_stream_if #(.data_bits_p(8)) if1 ();
    uart_tx_stream_if #(.data_bits_p(7)) if2 ();

    assign if0.valid_i = valid_v[0];
    assign if1.valid_i = valid_v[1];
    assign if2.valid_i = valid_v[2];
    assign if0.data_i  = data_v[0];
    assign if1.data_i  = data_v[1];
    assign if2.data_i  = data_v[2][6:0];
    assign yumi_w      = {if2.yumi_o, if1.yumi_o, if0.yumi_o};

    uart_tx_stream #(.clks_per_bit_p(4), .data_bits_p(8), .parity_p(0), .stop_bits_p(1)) dut0 (
        .clk_i(clk), .reset_i(reset), .fifo_if(if0.slave), .tx_o(tx_w[0]), .busy_o(busy_w[0]));
    uart_tx_stream #(.clks_per_bit_p(4), .data_bits_p(8), .parity_p(2), .stop_bits_p(2)) dut1 (
        .clk_i(clk), .reset_i(reset), .fifo_if(if1.slave), .tx_o(tx_w[1]), .busy_o(busy_w[1]));
    uart_tx_stream #(.clks_per_bit_p(2), .data_bits_p(7), .parity_p(1), .stop_bits_p(1)) dut2 (
        .clk_i(clk), .reset_i(reset), .fifo_if(if2.slave), .tx_o(tx_w[2]), .busy_o(busy_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // reference model: per DUT a FIFO image and the frame currently on the line
    logic [7:0]  mem   [3][256];
    int          idx   [3];
    int          avail [3];
    int          pos   [3];
    logic [15:0] frame [3];
    int          busy_run;

    function automatic int frame_bits(int k);
        return 1 + DB[k] + ((PAR[k] != 0) ? 1 : 0) + SB[k];
    endfunction

    function automatic logic [15:0] build_frame(int k, logic [7:0] b);
        logic [15:0] f;
        int p;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        p    = 1;
        ones = 0;
        for (int i = 0; i < DB[k]; i++) begin
            f[p] = b[i];
            ones += int'(b[i]);
            p++;
        end
        if (PAR[k] == 1) f[p] = ((ones % 2) == 0);
        if (PAR[k] == 2) f[p] = ((ones % 2) == 1);
        return f;
    endfunction

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s dut%0d cycle %0d: observed %b expected %b", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic push_all(input logic [7:0] b);
        for (int k = 0; k < 3; k++) begin
            if (avail[k] < 256) begin
                mem[k][avail[k]] = b;
                avail[k]++;
            end
        end
    endtask

    task automatic cycle(input logic rst_v, input logic [2:0] gate);
        logic exp_y, exp_tx, exp_busy;
        @(negedge clk);
        reset = rst_v;
        for (int k = 0; k < 3; k++) begin
            valid_v[k] = gate[k] && (idx[k] < avail[k]);
            data_v[k]  = valid_v[k] ? mem[k][idx[k]] : 8'($urandom);
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_y    = valid_v[k] && !rst_v &&
                       ((pos[k] < 0) || (pos[k] == frame_bits(k) * CPB[k] - 1));
            exp_tx   = (pos[k] < 0) ? 1'b1 : frame[k][pos[k] / CPB[k]];
            exp_busy = (pos[k] >= 0);
            chk("yumi", k, yumi_w[k], exp_y);
            chk("tx",   k, tx_w[k],   exp_tx);
            chk("busy", k, busy_w[k], exp_busy);
            if (rst_v) begin
                pos[k] = -1;
            end else if (exp_y) begin
                frame[k] = build_frame(k, mem[k][idx[k]]);
                idx[k]++;
                pos[k] = 0;
            end else if (pos[k] >= 0) begin
                pos[k]++;
                if (pos[k] == frame_bits(k) * CPB[k]) pos[k] = -1;
            end
        end
        if (busy_w[0]) busy_run++;
        cyc++;
    endtask

    initial begin
        reset   = 1'b1;
        valid_v = '0;
        for (int k = 0; k < 3; k++) begin
            data_v[k] = '0;
            idx[k]    = 0;
            avail[k]  = 0;
            pos[k]    = -1;
            frame[k]  = '1;
        end
        busy_run = 0;

        // reset with a byte already waiting: no pop may happen while reset is high
        push_all(8'hA5);
        repeat (3) cycle(1'b1, 3'b111);

        // single A5 frame on every configuration
        busy_run = 0;
        repeat (60) cycle(1'b0, 3'b111);
        chk("frame40_busy_cycles", 0, logic'(busy_run == 40), 1'b1);

        // back-to-back 00 then FF with valid held
        push_all(8'h00);
        push_all(8'hFF);
        busy_run = 0;
        repeat (110) cycle(1'b0, 3'b111);
        chk("b2b_busy_cycles", 0, logic'(busy_run == 80), 1'b1);

        // abort 3C during data bit 3 of dut0, then a clean frame
        push_all(8'h3C);
        repeat (19) cycle(1'b0, 3'b111);
        push_all(8'h5A);
        cycle(1'b1, 3'b111);
        repeat (60) cycle(1'b0, 3'b111);

        // idle with data toggling underneath
        repeat (20) cycle(1'b0, 3'b000);

        // random traffic, valid gating and occasional resets
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                int k;
                k = $urandom_range(0, 2);
                if (avail[k] < 256) begin
                    mem[k][avail[k]] = 8'($urandom);
                    avail[k]++;
                end
            end
            cycle(($urandom_range(0, 299) == 0), 3'($urandom | $urandom));
        end
        repeat (120) cycle(1'b0, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
